// File: rtl/br_flow_deserializer.sv
// br_flow_deserializer
// Reassembles a stream of narrow push slices into one wide pop flit. It sits at
// the far end of a narrow link, opposite a flow serializer.
//
// The first DR-1 slices of a flit are captured in slice registers. The final
// slice is not stored. It is steered straight into pop_data, so a flit pops in
// the same cycle its final slice is presented.
//
// A slice is final when it fills the last slot or when push_last is set. A short
// tail leaves unused slots; these are forced to zero and reported through
// pop_last_dont_care_count.
//
// Ports
//   clk                       posedge clock
//   rst                       synchronous, active-high reset
//   push_ready                slice accepted this cycle
//   push_valid                slice offered
//   push_data                 narrow slice (PushWidth)
//   push_last                 slice ends the packet
//   push_metadata             sideband, constant across the slices of one flit
//   pop_ready                 downstream accepts the wide flit
//   pop_valid                 wide flit offered
//   pop_data                  assembled flit (PopWidth)
//   pop_last                  flit ends the packet
//   pop_last_dont_care_count  zeroed tail slots, nonzero only with pop_last
//   pop_metadata              metadata of the final slice
module br_flow_deserializer #(
    parameter int PushWidth                       = 1,
    parameter int PopWidth                        = 2,
    parameter int MetadataWidth                   = 1,
    parameter bit DeserializeMostSignificantFirst = 0,
    parameter bit EnableAssertPushDataKnown       = 1,
    parameter bit EnableAssertFinalNotValid       = 1,
    localparam int DR  = PopWidth / PushWidth,
    localparam int IdW = (DR > 1) ? $clog2(DR) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     push_ready,
    input  logic                     push_valid,
    input  logic [PushWidth-1:0]     push_data,
    input  logic                     push_last,
    input  logic [MetadataWidth-1:0] push_metadata,
    input  logic                     pop_ready,
    output logic                     pop_valid,
    output logic [PopWidth-1:0]      pop_data,
    output logic                     pop_last,
    output logic [IdW-1:0]           pop_last_dont_care_count,
    output logic [MetadataWidth-1:0] pop_metadata
);

    localparam logic [IdW-1:0] LastId = IdW'(DR - 1);

    logic [IdW-1:0]       flit_id;
    logic                 final_slice;
    logic                 push_fire;
    logic [PushWidth-1:0] stored [DR];
    logic [PushWidth-1:0] slot_val;

    assign final_slice = (flit_id == LastId) || push_last;
    assign push_fire   = push_valid && push_ready;

    // A non-final slice is always accepted. A final slice can only be taken
    // when downstream takes the wide flit in the same cycle.
    assign push_ready = final_slice ? pop_ready : 1'b1;
    assign pop_valid  = final_slice && push_valid;

    assign pop_last                 = push_last;
    assign pop_last_dont_care_count = push_last ? (LastId - flit_id) : '0;
    assign pop_metadata             = push_metadata;

    // flit_id counts slices already stored. It goes back to zero only when a
    // final slice completes its handshake, so it cannot pass DR-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            flit_id <= '0;
        end else if (push_fire) begin
            flit_id <= final_slice ? '0 : flit_id + IdW'(1);
        end
    end

    // One register per storable slot. The last slot is never stored because the
    // final slice always bypasses into pop_data. With DR==1 no registers exist.
    for (genvar k = 0; k < DR; k++) begin : g_slot
        if (k < DR - 1) begin : g_reg
            logic [PushWidth-1:0] slot_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_q <= '0;
                end else if (push_fire && !final_slice && flit_id == IdW'(k)) begin
                    slot_q <= push_data;
                end
            end
            assign stored[k] = slot_q;
        end else begin : g_none
            assign stored[k] = '0;
        end
    end

    // Slots below flit_id come from the registers and slot flit_id comes from
    // push_data. Slots above flit_id are zeroed so an earlier, longer flit can
    // never leak into a short tail.
    always_comb begin
        pop_data = '0;
        slot_val = '0;
        for (int k = 0; k < DR; k++) begin
            if (IdW'(k) < flit_id) begin
                slot_val = stored[k];
            end else if (IdW'(k) == flit_id) begin
                slot_val = push_data;
            end else begin
                slot_val = '0;
            end
            if (DeserializeMostSignificantFirst) begin
                pop_data[(DR-1-k)*PushWidth +: PushWidth] = slot_val;
            end else begin
                pop_data[k*PushWidth +: PushWidth] = slot_val;
            end
        end
    end

`ifndef SYNTHESIS
    logic                     prev_push_stall;
    logic                     prev_pop_stall;
    logic [PushWidth-1:0]     prev_push_data;
    logic                     prev_push_last;
    logic [PopWidth-1:0]      prev_pop_data;
    logic [MetadataWidth-1:0] flit_meta;

    // These registers remember the previous cycle for the protocol checks.
    // flit_meta holds the metadata of slot 0 of the flit being assembled.
    always_ff @(posedge clk) begin
        prev_push_stall <= !rst && push_valid && !push_ready;
        prev_pop_stall  <= !rst && pop_valid && !pop_ready;
        prev_push_data  <= push_data;
        prev_push_last  <= push_last;
        prev_pop_data   <= pop_data;
        if (push_fire && flit_id == '0) begin
            flit_meta <= push_metadata;
        end
    end

    // Protocol checks. The integration checks cover the upstream side and the
    // implementation checks cover this block's own outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (EnableAssertPushDataKnown && push_valid) begin
                assert (!$isunknown(push_data));
            end
            if (prev_push_stall) begin
                assert (push_valid && push_data == prev_push_data && push_last == prev_push_last);
            end
            if (push_valid && flit_id != '0) begin
                assert (push_metadata == flit_meta);
            end
            assert (!pop_last || push_last);
            if (prev_pop_stall) begin
                assert (pop_valid && pop_data == prev_pop_data);
            end
            assert (!pop_valid || push_valid);
        end
    end

    // At the end of the run, no transfer may be left outstanding.
    final begin
        if (EnableAssertFinalNotValid) begin
            assert (!push_valid);
            assert (!pop_valid);
        end
    end
`endif

endmodule

// File: tb/tb_br_flow_deserializer.sv
// tb_br_flow_deserializer
// Self-checking bench for br_flow_deserializer. The bench uses 8-bit slices,
// 32-bit flits and 3-bit metadata.
//
// Two instances share the same push stimulus. One packs the first slice into
// the LSBs and the other packs it into the MSBs. Each expected flit is queued
// with both layouts before its final slice is driven. A monitor pops the queue
// whenever a flit handshakes.
//
// Ports: none. The bench generates clk, and rst is driven from the stimulus.
module tb_br_flow_deserializer;

    localparam int PushW = 8;
    localparam int PopW  = 32;
    localparam int MetaW = 3;
    localparam int IdW   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             push_valid;
    logic [PushW-1:0] push_data;
    logic             push_last;
    logic [MetaW-1:0] push_metadata;
    logic             pop_ready;

    logic             push_ready_l, pop_valid_l, pop_last_l;
    logic [PopW-1:0]  pop_data_l;
    logic [IdW-1:0]   dc_l;
    logic [MetaW-1:0] meta_l;

    logic             push_ready_m, pop_valid_m, pop_last_m;
    logic [PopW-1:0]  pop_data_m;
    logic [IdW-1:0]   dc_m;
    logic [MetaW-1:0] meta_m;

    typedef struct {
        logic [31:0] lsb;
        logic [31:0] msb;
        logic        last;
        logic [1:0]  dc;
        logic [2:0]  meta;
    } flit_t;

    flit_t       sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          model_id = 0;
    logic [7:0]  acc [4];

    always #5 clk = ~clk;

    br_flow_deserializer #(
        .PushWidth(PushW), .PopWidth(PopW), .MetadataWidth(MetaW),
        .DeserializeMostSignificantFirst(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .push_ready(push_ready_l), .push_valid(push_valid), .push_data(push_data),
        .push_last(push_last), .push_metadata(push_metadata),
        .pop_ready(pop_ready), .pop_valid(pop_valid_l), .pop_data(pop_data_l),
        .pop_last(pop_last_l), .pop_last_dont_care_count(dc_l), .pop_metadata(meta_l)
    );

    br_flow_deserializer #(
        .PushWidth(PushW), .PopWidth(PopW), .MetadataWidth(MetaW),
        .DeserializeMostSignificantFirst(1'b1)
    ) dut_msb (
        .clk(clk), .rst(rst),
        .push_ready(push_ready_m), .push_valid(push_valid), .push_data(push_data),
        .push_last(push_last), .push_metadata(push_metadata),
        .pop_ready(pop_ready), .pop_valid(pop_valid_m), .pop_data(pop_data_m),
        .pop_last(pop_last_m), .pop_last_dont_care_count(dc_m), .pop_metadata(meta_m)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expectFlit(input logic [31:0] lsb, input logic [31:0] msb,
                              input logic last, input logic [1:0] dc, input logic [2:0] meta);
        flit_t f;
        f.lsb = lsb; f.msb = msb; f.last = last; f.dc = dc; f.meta = meta;
        sb_q.push_back(f);
    endtask

    // Drives one slice starting just after a posedge. For a final slice,
    // pop_ready can first be held low for 'hold' cycles. The slice is always
    // accepted on the last posedge of the task.
    task automatic applyStimulus(input logic [7:0] d, input logic last,
                                 input logic [2:0] meta, input int hold);
        logic fin;
        fin = (model_id == 3) || last;
        push_valid    = 1'b1;
        push_data     = d;
        push_last     = last;
        push_metadata = meta;
        if (fin && hold > 0) begin
            pop_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                checkOutput("hold_pop_valid", {31'b0, pop_valid_l}, 32'd1);
                checkOutput("hold_push_ready", {31'b0, push_ready_l}, 32'd0);
                if (sb_q.size() > 0) begin
                    checkOutput("hold_pop_data", pop_data_l, sb_q[0].lsb);
                end else begin
                    checkOutput("hold_sb_nonempty", 32'd0, 32'd1);
                end
            end
            @(posedge clk);
            #1;
            pop_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput("push_ready", {31'b0, push_ready_l}, 32'd1);
        checkOutput("push_ready_msb", {31'b0, push_ready_m}, 32'd1);
        checkOutput("pop_valid", {31'b0, pop_valid_l}, {31'b0, fin});
        @(posedge clk);
        #1;
        if (fin) begin
            model_id = 0;
        end else begin
            acc[model_id] = d;
            model_id++;
        end
        push_valid = 1'b0;
        push_last  = 1'b0;
    endtask

    // Scoreboard side: every popped flit must match the oldest queued entry.
    always @(negedge clk) begin
        if (!rst && pop_valid_l && pop_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_pop", 32'd1, 32'd0);
            end else begin
                flit_t f;
                f = sb_q.pop_front();
                checkOutput("pop_data", pop_data_l, f.lsb);
                checkOutput("pop_data_msb", pop_data_m, f.msb);
                checkOutput("pop_valid_msb", {31'b0, pop_valid_m}, 32'd1);
                checkOutput("pop_last", {31'b0, pop_last_l}, {31'b0, f.last});
                checkOutput("pop_last_msb", {31'b0, pop_last_m}, {31'b0, f.last});
                checkOutput("dont_care", {30'b0, dc_l}, {30'b0, f.dc});
                checkOutput("dont_care_msb", {30'b0, dc_m}, {30'b0, f.dc});
                checkOutput("pop_meta", {29'b0, meta_l}, {29'b0, f.meta});
                checkOutput("pop_meta_msb", {29'b0, meta_m}, {29'b0, f.meta});
            end
        end
    end

    initial begin
        logic [2:0]  rmeta;
        logic [7:0]  d;
        logic        last;
        logic [31:0] lsb, msb;
        logic [7:0]  v;

        rst = 1'b1; push_valid = 1'b0; push_data = '0; push_last = 1'b0;
        push_metadata = '0; pop_ready = 1'b1;
        for (int i = 0; i < 4; i++) acc[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst_pop_valid", {31'b0, pop_valid_l}, 32'd0);
        checkOutput("rst_push_ready", {31'b0, push_ready_l}, 32'd1);
        push_valid = 1'b1; push_last = 1'b1; push_data = 8'hAA;
        @(negedge clk);
        checkOutput("rst_pop_valid_last", {31'b0, pop_valid_l}, 32'd1);
        checkOutput("rst_pop_data", pop_data_l, 32'h000000AA);
        checkOutput("rst_dont_care", {30'b0, dc_l}, 32'd3);
        @(posedge clk);
        #1;
        push_valid = 1'b0; push_last = 1'b0; rst = 1'b0;

        // Full flit, LSB-first assembly
        expectFlit(32'h01234567, 32'h67452301, 1'b0, 2'd0, 3'd2);
        applyStimulus(8'h67, 1'b0, 3'd2, 0);
        applyStimulus(8'h45, 1'b0, 3'd2, 0);
        applyStimulus(8'h23, 1'b0, 3'd2, 0);
        applyStimulus(8'h01, 1'b0, 3'd2, 0);

        // Full flit whose MSB-first form is BAADF00D
        expectFlit(32'h0DF0ADBA, 32'hBAADF00D, 1'b0, 2'd0, 3'd5);
        applyStimulus(8'hBA, 1'b0, 3'd5, 0);
        applyStimulus(8'hAD, 1'b0, 3'd5, 0);
        applyStimulus(8'hF0, 1'b0, 3'd5, 0);
        applyStimulus(8'h0D, 1'b0, 3'd5, 0);

        // Short tail after a full flit: the old top byte must be zeroed
        expectFlit(32'h00ADF00D, 32'h0DF0AD00, 1'b1, 2'd1, 3'd1);
        applyStimulus(8'h0D, 1'b0, 3'd1, 0);
        applyStimulus(8'hF0, 1'b0, 3'd1, 0);
        applyStimulus(8'hAD, 1'b1, 3'd1, 0);

        // Single-slice packet at flit_id 0, followed by a full flit that
        // confirms flit_id stayed at 0
        expectFlit(32'h000000AA, 32'hAA000000, 1'b1, 2'd3, 3'd7);
        applyStimulus(8'hAA, 1'b1, 3'd7, 0);
        expectFlit(32'h44332211, 32'h11223344, 1'b0, 2'd0, 3'd3);
        applyStimulus(8'h11, 1'b0, 3'd3, 0);
        applyStimulus(8'h22, 1'b0, 3'd3, 0);
        applyStimulus(8'h33, 1'b0, 3'd3, 0);
        applyStimulus(8'h44, 1'b0, 3'd3, 0);

        // Backpressure on the final slice for 3 cycles
        expectFlit(32'hD4C3B2A1, 32'hA1B2C3D4, 1'b0, 2'd0, 3'd4);
        applyStimulus(8'hA1, 1'b0, 3'd4, 0);
        applyStimulus(8'hB2, 1'b0, 3'd4, 0);
        applyStimulus(8'hC3, 1'b0, 3'd4, 0);
        applyStimulus(8'hD4, 1'b0, 3'd4, 3);

        // Mid-operation reset drops two partial slices
        applyStimulus(8'hEE, 1'b0, 3'd6, 0);
        applyStimulus(8'hFF, 1'b0, 3'd6, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_id = 0;
        @(negedge clk);
        checkOutput("post_rst_pop_valid", {31'b0, pop_valid_l}, 32'd0);
        @(posedge clk);
        #1;
        expectFlit(32'h44332211, 32'h11223344, 1'b1, 2'd0, 3'd2);
        applyStimulus(8'h11, 1'b0, 3'd2, 0);
        applyStimulus(8'h22, 1'b0, 3'd2, 0);
        applyStimulus(8'h33, 1'b0, 3'd2, 0);
        applyStimulus(8'h44, 1'b1, 3'd2, 0);

        // Random packets. Each expected flit is built from the slices sent.
        rmeta = 3'($urandom);
        for (int n = 0; n < 60; n++) begin
            d    = 8'($urandom);
            last = ($urandom_range(0, 3) == 0);
            if (model_id == 3 || last) begin
                lsb = '0;
                msb = '0;
                for (int k = 0; k < 4; k++) begin
                    if (k < model_id)       v = acc[k];
                    else if (k == model_id) v = d;
                    else                    v = 8'h00;
                    lsb[k*8 +: 8]     = v;
                    msb[(3-k)*8 +: 8] = v;
                end
                expectFlit(lsb, msb, last, last ? 2'(3 - model_id) : 2'd0, rmeta);
                applyStimulus(d, last, rmeta, (n % 7 == 0) ? 2 : 0);
                rmeta = 3'($urandom);
            end else begin
                applyStimulus(d, last, rmeta, 0);
            end
        end

        repeat (3) @(posedge clk);
        checkOutput("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
